// File: rtl/rt_pkg.sv
// ---------------------------------------------------------------------------
// rt_pkg
//   Shared defaults for the RISC_TOY fetch front end: instruction and
//   word-address widths, the default reset fetch address, and the layout of
//   one buffered fetch entry (instruction word plus the PC it came from).
// ---------------------------------------------------------------------------
package rt_pkg;

  localparam int RT_DW = 32;
  localparam int RT_AW = 30;

  localparam logic [RT_AW-1:0] RT_RESET_PC = '0;

  typedef struct packed {
    logic [RT_DW-1:0] instr;
    logic [RT_AW-1:0] pc;
  } rt_fetch_entry_t;

endpackage

// File: rtl/rt_sync_fifo.sv
// ---------------------------------------------------------------------------
// rt_sync_fifo
//   Single-clock FIFO of DEPTH entries of type entry_t with a synchronous
//   clear. The head entry is read combinationally (no output register).
//   Ports:
//     clk_i    clock
//     rst_i    asynchronous active-high reset (pointers, count and storage)
//     clear_i  synchronous flush; wins over push/pop in the same cycle
//     push_i   write wdata_i at the tail
//     pop_i    advance the head
//     wdata_i  entry to write
//     rdata_o  current head entry
//     count_o  occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module rt_sync_fifo
  import rt_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = rt_fetch_entry_t,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  entry_t        wdata_i,
  output entry_t        rdata_o,
  output logic [CW-1:0] count_o
);

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic pop_ok;
  logic push_ok;

  // Guard both sides so a misbehaving caller cannot corrupt the pointers;
  // a push into a full queue is allowed only when the head leaves together.
  assign pop_ok  = pop_i && (count_q != '0);
  assign push_ok = push_i && ((count_q != CW'(DEPTH)) || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
      else if (pop_ok && !push_ok) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/rt_fetch_queue.sv
// ---------------------------------------------------------------------------
// rt_fetch_queue
//   Instruction-fetch front end for the RISC_TOY pipeline. Issues word
//   fetches to instruction memory (fixed one-cycle read latency), buffers the
//   returned words with their PCs in a DEPTH-entry queue and presents the head
//   to ID over valid/ready. A redirect from EX flushes the queue, drops the
//   response arriving in the same cycle and issues the target immediately.
//   Ports:
//     CLK          clock
//     RST          asynchronous active-high reset
//     IREQ         fetch request this cycle
//     IADDR        fetch word address
//     INSTR        memory data for the previous cycle's request
//     REDIR_VALID  redirect from EX
//     REDIR_ADDR   redirect target word address
//     DEC_VALID    head entry valid to ID
//     DEC_READY    ID accepts the head
//     DEC_INSTR    head instruction
//     DEC_PC       head instruction word address
//     COUNT        queue occupancy
// ---------------------------------------------------------------------------
module rt_fetch_queue
  import rt_pkg::*;
#(
  parameter int            DW       = RT_DW,
  parameter int            AW       = RT_AW,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = AW'(RT_RESET_PC),
  localparam int           CW       = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  output logic          IREQ,
  output logic [AW-1:0] IADDR,
  input  logic [DW-1:0] INSTR,
  input  logic          REDIR_VALID,
  input  logic [AW-1:0] REDIR_ADDR,
  output logic          DEC_VALID,
  input  logic          DEC_READY,
  output logic [DW-1:0] DEC_INSTR,
  output logic [AW-1:0] DEC_PC,
  output logic [CW-1:0] COUNT
);

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [AW-1:0] pc;
  } entry_t;

  logic [AW-1:0] fpc_q, fpc_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] tag_q, tag_d;

  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic          credit_ok;
  logic          issue;
  logic          push;
  logic          pop;
  entry_t        push_entry;
  entry_t        head_entry;

  // The outstanding fetch already owns a slot, so counting it here is what
  // keeps the queue from ever overflowing without a full-flag check on push.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q};
  assign credit_ok = occupancy < (CW+1)'(DEPTH);

  assign issue = !RST && (REDIR_VALID || credit_ok);
  assign IREQ  = issue;
  assign IADDR = REDIR_VALID ? REDIR_ADDR : fpc_q;

  // A redirect in this cycle makes the arriving response wrong-path.
  assign push       = inflight_q && !REDIR_VALID;
  assign push_entry = '{instr: INSTR, pc: tag_q};

  assign DEC_VALID = (count != '0) && !REDIR_VALID;
  assign pop       = DEC_VALID && DEC_READY;

  always_comb begin
    fpc_d      = fpc_q;
    tag_d      = tag_q;
    inflight_d = 1'b0;
    if (issue) begin
      fpc_d      = IADDR + AW'(1);
      tag_d      = IADDR;
      inflight_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fpc_q      <= RESET_PC;
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      fpc_q      <= fpc_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
    end
  end

  rt_sync_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .clear_i (REDIR_VALID),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_entry),
    .rdata_o (head_entry),
    .count_o (count)
  );

  assign DEC_INSTR = head_entry.instr;
  assign DEC_PC    = head_entry.pc;
  assign COUNT     = count;

endmodule

// File: tb/tb_rt_fetch_queue.sv
module tb_rt_fetch_queue;

  logic clk;

  // DUT A: default parameters (RESET_PC = 0)
  logic        rst_a;
  logic        ireq_a;
  logic [29:0] iaddr_a;
  logic [31:0] instr_a;
  logic        redir_v_a;
  logic [29:0] redir_addr_a;
  logic        dec_valid_a;
  logic        dec_ready_a;
  logic [31:0] dec_instr_a;
  logic [29:0] dec_pc_a;
  logic [2:0]  count_a;

  // DUT B: RESET_PC near the top of the address space
  logic        rst_b;
  logic        ireq_b;
  logic [29:0] iaddr_b;
  logic [31:0] instr_b;
  logic        redir_v_b;
  logic [29:0] redir_addr_b;
  logic        dec_valid_b;
  logic        dec_ready_b;
  logic [31:0] dec_instr_b;
  logic [29:0] dec_pc_b;
  logic [2:0]  count_b;

  int n_cmp;
  int n_err;

  rt_fetch_queue u_dut_a (
    .CLK         (clk),
    .RST         (rst_a),
    .IREQ        (ireq_a),
    .IADDR       (iaddr_a),
    .INSTR       (instr_a),
    .REDIR_VALID (redir_v_a),
    .REDIR_ADDR  (redir_addr_a),
    .DEC_VALID   (dec_valid_a),
    .DEC_READY   (dec_ready_a),
    .DEC_INSTR   (dec_instr_a),
    .DEC_PC      (dec_pc_a),
    .COUNT       (count_a)
  );

  rt_fetch_queue #(
    .RESET_PC (30'h3FFF_FFFE)
  ) u_dut_b (
    .CLK         (clk),
    .RST         (rst_b),
    .IREQ        (ireq_b),
    .IADDR       (iaddr_b),
    .INSTR       (instr_b),
    .REDIR_VALID (redir_v_b),
    .REDIR_ADDR  (redir_addr_b),
    .DEC_VALID   (dec_valid_b),
    .DEC_READY   (dec_ready_b),
    .DEC_INSTR   (dec_instr_b),
    .DEC_PC      (dec_pc_b),
    .COUNT       (count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: one-cycle latency, word = A000_0000 | address.
  always @(posedge clk) begin
    instr_a <= 32'hA000_0000 | {2'b00, iaddr_a};
    instr_b <= 32'hA000_0000 | {2'b00, iaddr_b};
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Leaves the caller 1 time unit after a rising edge, i.e. at the start of a cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Assert reset for two edges, release at the start of cycle c0.
  task automatic reset_a(input logic rdy);
    rst_a        = 1'b1;
    redir_v_a    = 1'b0;
    redir_addr_a = '0;
    dec_ready_a  = rdy;
    tick();
    tick();
    rst_a = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    logic [29:0] exp_pc;
    logic [29:0] exp_b [6];
    int          n_acc;

    n_cmp = 0;
    n_err = 0;
    rst_a = 1'b1;  redir_v_a = 1'b0; redir_addr_a = '0; dec_ready_a = 1'b1;
    rst_b = 1'b1;  redir_v_b = 1'b0; redir_addr_b = '0; dec_ready_b = 1'b1;

    // Reset state
    #2;
    check_eq("rst_ireq",      ireq_a,      0);
    check_eq("rst_iaddr",     iaddr_a,     0);
    check_eq("rst_dec_valid", dec_valid_a, 0);
    check_eq("rst_dec_instr", dec_instr_a, 0);
    check_eq("rst_dec_pc",    dec_pc_a,    0);
    check_eq("rst_count",     count_a,     0);
    check_eq("rst_b_iaddr",   iaddr_b,     30'h3FFF_FFFE);
    check_eq("rst_b_ireq",    ireq_b,      0);

    // 1: streaming from reset with ID always ready
    tick();
    rst_a = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      check_eq("t1_ireq",  ireq_a,  1);
      check_eq("t1_iaddr", iaddr_a, 30'(k));
      if (k < 2) begin
        check_eq("t1_dec_valid_lat", dec_valid_a, 0);
      end else begin
        check_eq("t1_dec_valid", dec_valid_a, 1);
        check_eq("t1_dec_pc",    dec_pc_a,    30'(k - 2));
        check_eq("t1_dec_instr", dec_instr_a, 32'hA000_0000 | 32'(k - 2));
      end
      tick();
    end

    // 2: ID stalled from reset, then released
    reset_a(1'b0);
    for (int k = 0; k < 6; k++) begin
      #1;
      if (k < 4) begin
        check_eq("t2_ireq",  ireq_a,  1);
        check_eq("t2_iaddr", iaddr_a, 30'(k));
      end else begin
        check_eq("t2_ireq_full", ireq_a, 0);
      end
      if (k == 5) check_eq("t2_count_full", count_a, 4);
      tick();
    end
    dec_ready_a = 1'b1;
    exp_pc = '0;
    n_acc  = 0;
    for (int j = 0; j < 8; j++) begin
      #1;
      if (j == 0) begin
        check_eq("t2_count_c6", count_a, 4);
        check_eq("t2_ireq_c6",  ireq_a,  0);
      end
      if (j == 1) begin
        check_eq("t2_resume_ireq",  ireq_a,  1);
        check_eq("t2_resume_iaddr", iaddr_a, 4);
      end
      if (dec_valid_a && dec_ready_a) begin
        check_eq("t2_pop_pc",    dec_pc_a,    exp_pc);
        check_eq("t2_pop_instr", dec_instr_a, 32'hA000_0000 | {2'b00, exp_pc});
        exp_pc = exp_pc + 30'd1;
        n_acc++;
      end
      tick();
    end
    check_eq("t2_pop_count", n_acc, 8);

    // 3: redirect with PCs 5,6,7 queued and 8 in flight
    reset_a(1'b0);
    redir_v_a    = 1'b1;
    redir_addr_a = 30'd5;
    #1;
    check_eq("t3_seed_iaddr", iaddr_a, 5);
    tick();
    redir_v_a = 1'b0;
    for (int k = 1; k < 4; k++) begin
      #1;
      check_eq("t3_fill_iaddr", iaddr_a, 30'(5 + k));
      tick();
    end
    redir_v_a    = 1'b1;
    redir_addr_a = 30'h100;
    #1;
    check_eq("t3_count_before", count_a,     3);
    check_eq("t3_head_before",  dec_pc_a,    5);
    check_eq("t3_dec_valid",    dec_valid_a, 0);
    check_eq("t3_ireq",         ireq_a,      1);
    check_eq("t3_iaddr",        iaddr_a,     30'h100);
    tick();
    redir_v_a   = 1'b0;
    dec_ready_a = 1'b1;
    #1;
    check_eq("t3_count_flush", count_a,     0);
    check_eq("t3_valid_flush", dec_valid_a, 0);
    check_eq("t3_iaddr_next",  iaddr_a,     30'h101);
    tick();
    #1;
    check_eq("t3_first_valid", dec_valid_a, 1);
    check_eq("t3_first_pc",    dec_pc_a,    30'h100);
    check_eq("t3_first_instr", dec_instr_a, 32'hA000_0100);
    tick();
    #1;
    check_eq("t3_second_pc", dec_pc_a, 30'h101);

    // 4: redirect while ID ready with two queued, then a back-to-back redirect
    reset_a(1'b0);
    tick();
    tick();
    tick();
    redir_v_a    = 1'b1;
    redir_addr_a = 30'h40;
    dec_ready_a  = 1'b1;
    #1;
    check_eq("t4_count",     count_a,     2);
    check_eq("t4_dec_valid", dec_valid_a, 0);
    check_eq("t4_iaddr",     iaddr_a,     30'h40);
    tick();
    redir_addr_a = 30'h80;
    #1;
    check_eq("t4_b2b_count", count_a, 0);
    check_eq("t4_b2b_iaddr", iaddr_a, 30'h80);
    tick();
    redir_v_a = 1'b0;
    #1;
    check_eq("t4_count_after", count_a,     0);
    check_eq("t4_valid_after", dec_valid_a, 0);
    tick();
    #1;
    check_eq("t4_final_valid", dec_valid_a, 1);
    check_eq("t4_final_pc",    dec_pc_a,    30'h80);

    // 5: fetch address wraps from the top of the word space
    exp_b[0] = 30'h3FFF_FFFE;
    exp_b[1] = 30'h3FFF_FFFF;
    exp_b[2] = 30'h0000_0000;
    exp_b[3] = 30'h0000_0001;
    exp_b[4] = 30'h0000_0002;
    exp_b[5] = 30'h0000_0003;
    rst_b = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (k < 4) check_eq("t5_iaddr", iaddr_b, exp_b[k]);
      if (k >= 2) begin
        check_eq("t5_dec_valid", dec_valid_b, 1);
        check_eq("t5_dec_pc",    dec_pc_b,    exp_b[k-2]);
      end
      if (k == 2) check_eq("t5_dec_instr", dec_instr_b, 32'hBFFF_FFFE);
      tick();
    end

    // 6: short reset pulse in the middle of streaming
    reset_a(1'b1);
    tick();
    tick();
    tick();
    tick();
    #2;
    rst_a = 1'b1;
    #1;
    check_eq("t6_ireq_in_rst",  ireq_a,      0);
    check_eq("t6_valid_in_rst", dec_valid_a, 0);
    check_eq("t6_count_in_rst", count_a,     0);
    rst_a = 1'b0;
    #1;
    check_eq("t6_ireq_release",  ireq_a,  1);
    check_eq("t6_iaddr_release", iaddr_a, 0);
    tick();
    #1;
    check_eq("t6_count_c5", count_a,     0);
    check_eq("t6_valid_c5", dec_valid_a, 0);
    tick();
    #1;
    check_eq("t6_first_valid", dec_valid_a, 1);
    check_eq("t6_first_pc",    dec_pc_a,    0);
    check_eq("t6_first_instr", dec_instr_a, 32'hA000_0000);
    tick();
    #1;
    check_eq("t6_second_pc", dec_pc_a, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
